fetch_stage: RTL and testbench

IF stage of the 5-stage RISC-V pipeline.
- Owns the PC register and issues in-order requests to an instruction memory with a valid/ready request channel and variable latency.
- Buffers returned instructions and presents read_data / pcf / pc_plus_4F to the IF/ID pipeline register.
- Handles hazard-unit stalls and EX-stage redirects (branch/jump).
- Uses an epoch bit to discard responses that were in flight when a redirect occurred.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V IF stage: PC, credit-limited imem requests, epoch-tagged response buffer
// Optional perf counters are enabled with `define FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_f,
    input  logic        redirect,
    input  logic [31:0] pc_target,
    output logic        instr_valid,
    output logic [31:0] read_data,
    output logic [31:0] pcf,
    output logic [31:0] pc_plus_4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] drop_cnt,
    output logic [31:0] stall_cycles
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic          epoch;

    logic [31:0]   tag_pc [DEPTH];
    logic          tag_ep [DEPTH];
    logic [PW-1:0] tag_wr, tag_rd;
    logic [CW-1:0] tag_count;

    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [PW-1:0] buf_wr, buf_rd;
    logic [CW-1:0] buf_count;

    logic [CW:0]   credit_used;
    logic          req_fire, rsp_fire, rsp_keep, rsp_drop, buf_pop;
    logic          unused_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    // Stale in-flight requests still hold credit, so the buffer can never overflow.
    assign credit_used    = {1'b0, tag_count} + {1'b0, buf_count};
    assign imem_req_valid = rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (tag_count != '0);
    // A response in the redirect cycle carries the pre-toggle epoch and is discarded.
    assign rsp_keep = rsp_fire && !redirect && (tag_ep[tag_rd] == epoch);
    assign rsp_drop = rsp_fire && !rsp_keep;

    assign instr_valid = (buf_count != '0);
    assign buf_pop     = instr_valid && !stall_f && !redirect;
    assign read_data   = instr_valid ? buf_data[buf_rd] : '0;
    assign pcf         = instr_valid ? buf_pc[buf_rd]   : '0;
    assign pc_plus_4F  = instr_valid ? pcf + 32'd4      : '0;

    assign unused_ok = &{1'b0, pc_target[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            epoch <= 1'b0;
        end else if (redirect) begin
            pc_q  <= {pc_target[31:2], 2'b00};
            epoch <= ~epoch;
        end else if (req_fire) begin
            pc_q  <= pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr    <= '0;
            tag_rd    <= '0;
            tag_count <= '0;
        end else begin
            if (req_fire)
                tag_wr <= ptr_inc(tag_wr);
            if (rsp_fire)
                tag_rd <= ptr_inc(tag_rd);
            case ({req_fire, rsp_fire})
                2'b10:   tag_count <= tag_count + CW'(1);
                2'b01:   tag_count <= tag_count - CW'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else if (redirect) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else begin
            if (rsp_keep)
                buf_wr <= ptr_inc(buf_wr);
            if (buf_pop)
                buf_rd <= ptr_inc(buf_rd);
            case ({rsp_keep, buf_pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= pc_q;
            tag_ep[tag_wr] <= epoch;
        end
        if (rsp_keep) begin
            buf_data[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]   <= tag_pc[tag_rd];
        end
    end

    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (tag_count != '0));

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt    <= '0;
            drop_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            if (req_fire)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (rsp_drop)
                drop_cnt <= drop_cnt + 32'd1;
            if (stall_f && instr_valid)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a queued instruction memory model
module tb_fetch_stage;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_f, redirect;
    logic [31:0] pc_target;
    logic        instr_valid;
    logic [31:0] read_data, pcf, pc_plus_4F;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, drop_cnt, stall_cycles;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall_f(stall_f), .redirect(redirect), .pc_target(pc_target),
        .instr_valid(instr_valid), .read_data(read_data), .pcf(pcf),
        .pc_plus_4F(pc_plus_4F)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt), .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic ep; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

    tag_t        mem_q[$];
    ins_t        sb[$];
    logic [31:0] exp_pc, rsp_pc;
    logic        bep, rsp_ep, rsp_en;
    int          n_fetch, n_drop, n_stall;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0013_0093;
    endfunction

    task automatic reset_model();
        mem_q.delete();
        sb.delete();
        exp_pc         = RESET_PC;
        bep            = 1'b0;
        n_fetch        = 0;
        n_drop         = 0;
        n_stall        = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    // Called just after a posedge: drives this cycle's response, checks mid-cycle, advances the model.
    task automatic cycle();
        tag_t t;
        ins_t e;
        logic exp_valid;
        if (rst && rsp_en && mem_q.size() > 0) begin
            t = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(t.pc);
            rsp_pc = t.pc;
            rsp_ep = t.ep;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
        if (rst) begin
            exp_valid = !redirect &&
                        (mem_q.size() + int'(imem_rsp_valid) + sb.size() < DEPTH);
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
            check("instr_valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
            if (sb.size() != 0) begin
                check("pcf", pcf, sb[0].pc);
                check("read_data", read_data, sb[0].data);
                check("pc_plus_4F", pc_plus_4F, sb[0].pc + 32'd4);
            end else begin
                check("idle_data", read_data, 32'h0);
                check("idle_pcf", pcf, 32'h0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                mem_q.push_back('{pc: exp_pc, ep: bep});
                exp_pc = exp_pc + 32'd4;
                n_fetch++;
            end
            if (instr_valid && stall_f)
                n_stall++;
            if (sb.size() != 0 && !stall_f && !redirect)
                void'(sb.pop_front());
            if (imem_rsp_valid) begin
                if (rsp_ep == bep && !redirect) begin
                    e.pc   = rsp_pc;
                    e.data = mem_word(rsp_pc);
                    sb.push_back(e);
                end else begin
                    n_drop++;
                end
            end
            if (redirect) begin
                sb.delete();
                bep    = ~bep;
                exp_pc = {pc_target[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        stall_f        = 1'b0;
        redirect       = 1'b0;
        pc_target      = '0;
        rsp_en         = 1'b1;
        rsp_pc         = '0;
        rsp_ep         = 1'b0;
        reset_model();
        #3;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_pcf", pcf, 32'h0);
        check("rst_pc_plus_4F", pc_plus_4F, 32'h0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // streaming from reset
        repeat (12) cycle();

        // stall holds the head while credits run out
        stall_f = 1'b1;
        repeat (3) cycle();
        check("stall_credit", {31'b0, imem_req_valid}, 32'h0);
        stall_f = 1'b0;
        repeat (6) cycle();

        // redirect with two requests in flight
        rsp_en = 1'b0;
        repeat (4) cycle();
        redirect  = 1'b1;
        pc_target = 32'h0000_0103;
        rsp_en    = 1'b1;
        cycle();
        redirect = 1'b0;
        repeat (8) cycle();
`ifdef FETCH_PERF_EN
        check("drop_cnt", drop_cnt, n_drop);
`endif

        // ready low: address and PC must hold
        imem_req_ready = 1'b0;
        repeat (5) begin
            cycle();
            check("addr_hold", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        repeat (6) cycle();

        // PC wrap at the top of the address space
        redirect  = 1'b1;
        pc_target = 32'hFFFF_FFFE;
        cycle();
        redirect = 1'b0;
        repeat (10) cycle();

        // randomized mix of stalls, back-pressure, latency and redirects
        repeat (60) begin
            stall_f        = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            rsp_en         = ($urandom_range(0, 3) != 0);
            redirect       = ($urandom_range(0, 9) == 0);
            pc_target      = $urandom;
            cycle();
        end
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;

`ifdef FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt, n_fetch);
        check("drop_cnt_total", drop_cnt, n_drop);
        check("stall_cycles", stall_cycles, n_stall);
`endif

        // async reset with the buffer occupied
        stall_f = 1'b1;
        repeat (6) cycle();
        #2;
        rst = 1'b0;
        #1;
        check("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("async_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("async_read_data", read_data, 32'h0);
        check("async_pcf", pcf, 32'h0);
        check("async_pc_plus_4F", pc_plus_4F, 32'h0);
        reset_model();
        stall_f = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("restart_addr", imem_req_addr, RESET_PC);
        repeat (8) cycle();
`ifdef FETCH_PERF_EN
        check("fetch_cnt_restart", fetch_cnt, n_fetch);
`endif

        // drain: stop issuing and let everything return
        imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && (mem_q.size() + sb.size()) != 0; i++)
            cycle();
        check("drained", {31'b0, instr_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
